updown_counter_bcd_mod: RTL and testbench

//   Parametrised N-digit BCD counter with a programmable modulus for clock, timer and stopwatch datapaths.

---
 rtl/updown_counter_bcd_mod.sv | 131 +++++++++++++
 tb/tb_updown_counter_bcd_mod.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_bcd_mod.sv
// N-digit BCD up/down counter with programmable modulus, counted on falling edges of a slow tick.
// Supports clear, validated parallel load, and registered one-cycle carry/borrow and load-error pulses.
module updown_counter_bcd_mod #(
    parameter int DIGITS    = 2,
    parameter int MODULUS   = 60,
    parameter int DOWN_STOP = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tick,
    input  logic                enable,
    input  logic                up_down,
    input  logic                clear,
    input  logic                load_enable,
    input  logic [4*DIGITS-1:0] load_bcd,
    output logic [4*DIGITS-1:0] bcd,
    output logic                carry,
    output logic                zero,
    output logic                load_err
);
    localparam int W = 4 * DIGITS;

    // One spare digit so MODULUS == 10**DIGITS is still representable.
    function automatic logic [W+3:0] to_bcd(input int v);
        logic [W+3:0] r;
        int           t;
        r = '0;
        t = v;
        for (int i = 0; i <= DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    localparam logic [W+3:0] MOD_BCD = to_bcd(MODULUS);
    localparam logic [W-1:0] MAX_BCD = W'(to_bcd(MODULUS - 1));

    logic         tick_q;
    logic [W-1:0] bcd_q, bcd_d;
    logic         carry_q, carry_d;
    logic         load_err_q, load_err_d;
    logic [W-1:0] inc_bcd, dec_bcd;
    logic         load_ok;
    logic         nedge;

    assign nedge = tick_q & ~tick;

    // Ripple increment/decrement; both are only used when no wrap occurs.
    always_comb begin
        logic c, b;
        c       = 1'b1;
        b       = 1'b1;
        inc_bcd = bcd_q;
        dec_bcd = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (bcd_q[4*i +: 4] == 4'd9) begin
                    inc_bcd[4*i +: 4] = 4'd0;
                end else begin
                    inc_bcd[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
            if (b) begin
                if (bcd_q[4*i +: 4] == 4'd0) begin
                    dec_bcd[4*i +: 4] = 4'd9;
                end else begin
                    dec_bcd[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
    end

    // Packed BCD with legal digits orders the same as its decimal value.
    always_comb begin
        load_ok = ({4'h0, load_bcd} < MOD_BCD);
        for (int i = 0; i < DIGITS; i++) begin
            if (load_bcd[4*i +: 4] > 4'd9) load_ok = 1'b0;
        end
    end

    always_comb begin
        bcd_d      = bcd_q;
        carry_d    = 1'b0;
        load_err_d = 1'b0;
        if (clear) begin
            bcd_d = '0;
        end else if (load_enable) begin
            if (load_ok) bcd_d = load_bcd;
            else         load_err_d = ~load_err_q;
        end else if (nedge && enable) begin
            if (up_down) begin
                if (bcd_q == MAX_BCD) begin
                    bcd_d   = '0;
                    carry_d = 1'b1;
                end else begin
                    bcd_d = inc_bcd;
                end
            end else if (bcd_q == '0) begin
                if (DOWN_STOP == 0) begin
                    bcd_d   = MAX_BCD;
                    carry_d = 1'b1;
                end
            end else begin
                bcd_d = dec_bcd;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q     <= 1'b0;
            bcd_q      <= '0;
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            tick_q     <= tick;
            bcd_q      <= bcd_d;
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
        end
    end

    assign bcd      = bcd_q;
    assign carry    = carry_q;
    assign load_err = load_err_q;
    assign zero     = (bcd_q == '0);

endmodule

// File: tb/tb_updown_counter_bcd_mod.sv
// Bench for updown_counter_bcd_mod: three configurations share one stimulus stream and are
// checked every cycle against an integer-arithmetic model, plus literal spot checks.
module tb_updown_counter_bcd_mod;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, tick, enable, up_down, clear, load_enable;
    logic [11:0] lb;
    logic [7:0]  bcd0, bcd1;
    logic [11:0] bcd2;
    logic        c0, c1, c2, z0, z1, z2, e0, e1, e2;

    updown_counter_bcd_mod #(.DIGITS(2), .MODULUS(60), .DOWN_STOP(0)) u0 (
        .clk(clk), .reset_n(reset_n), .tick(tick), .enable(enable), .up_down(up_down),
        .clear(clear), .load_enable(load_enable), .load_bcd(lb[7:0]),
        .bcd(bcd0), .carry(c0), .zero(z0), .load_err(e0));
    updown_counter_bcd_mod #(.DIGITS(2), .MODULUS(60), .DOWN_STOP(1)) u1 (
        .clk(clk), .reset_n(reset_n), .tick(tick), .enable(enable), .up_down(up_down),
        .clear(clear), .load_enable(load_enable), .load_bcd(lb[7:0]),
        .bcd(bcd1), .carry(c1), .zero(z1), .load_err(e1));
    updown_counter_bcd_mod #(.DIGITS(3), .MODULUS(100), .DOWN_STOP(0)) u2 (
        .clk(clk), .reset_n(reset_n), .tick(tick), .enable(enable), .up_down(up_down),
        .clear(clear), .load_enable(load_enable), .load_bcd(lb),
        .bcd(bcd2), .carry(c2), .zero(z2), .load_err(e2));

    localparam int DG[3] = '{2, 2, 3};
    localparam int MD[3] = '{60, 60, 100};
    localparam int DS[3] = '{0, 1, 0};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string n, input logic [11:0] a, input logic [11:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
        end
    endtask

    function automatic logic [11:0] tobcd(input int v);
        logic [11:0] r;
        int t;
        t = v;
        for (int i = 0; i < 3; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Decimal value of the load word seen by instance k, or -1 for a non-decimal digit.
    function automatic int ldec(input int k, input logic [11:0] v);
        int val, w, nib;
        val = 0;
        w   = 1;
        for (int i = 0; i < DG[k]; i++) begin
            nib = int'(v[4*i +: 4]);
            if (nib > 9) return -1;
            val = val + nib * w;
            w   = w * 10;
        end
        return val;
    endfunction

    int   cnt[3];
    logic mc[3], me[3];
    logic tprev;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tprev <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                cnt[k] <= 0;
                mc[k]  <= 1'b0;
                me[k]  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                mc[k] <= 1'b0;
                me[k] <= 1'b0;
                if (clear) cnt[k] <= 0;
                else if (load_enable) begin
                    if (ldec(k, lb) >= 0 && ldec(k, lb) < MD[k]) cnt[k] <= ldec(k, lb);
                    else me[k] <= !me[k];
                end else if (tprev && !tick && enable) begin
                    if (up_down) begin
                        if (cnt[k] == MD[k] - 1) begin cnt[k] <= 0; mc[k] <= 1'b1; end
                        else cnt[k] <= cnt[k] + 1;
                    end else if (cnt[k] == 0) begin
                        if (DS[k] == 0) begin cnt[k] <= MD[k] - 1; mc[k] <= 1'b1; end
                    end else cnt[k] <= cnt[k] - 1;
                end
            end
            tprev <= tick;
        end
    end

    task automatic cmp_inst(input string n, input int k, input logic [11:0] b,
                            input logic c, input logic z, input logic e);
        chk({n, ".bcd"},      b,            tobcd(cnt[k]));
        chk({n, ".carry"},    {11'b0, c},   {11'b0, mc[k]});
        chk({n, ".zero"},     {11'b0, z},   {11'b0, cnt[k] == 0});
        chk({n, ".load_err"}, {11'b0, e},   {11'b0, me[k]});
    endtask

    always @(negedge clk) begin
        cmp_inst("u0", 0, {4'h0, bcd0}, c0, z0, e0);
        cmp_inst("u1", 1, {4'h0, bcd1}, c1, z1, e1);
        cmp_inst("u2", 2, bcd2, c2, z2, e2);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fall();
        tick = 1'b1; cyc(1);
        tick = 1'b0; cyc(1);
    endtask

    task automatic load(input logic [11:0] v);
        load_enable = 1'b1; lb = v; cyc(1);
        load_enable = 1'b0;
    endtask

    initial begin
        reset_n = 1'b1; tick = 1'b0; enable = 1'b0; up_down = 1'b0;
        clear = 1'b0; load_enable = 1'b0; lb = '0;
        #1 reset_n = 1'b0;
        cyc(2);
        chk("rst.bcd0", {4'h0, bcd0}, 12'h000);
        chk("rst.zero0", {11'b0, z0}, 12'h001);
        chk("rst.carry0", {11'b0, c0}, 12'h000);
        reset_n = 1'b1;
        cyc(1);

        // up through the 59 -> 00 wrap
        up_down = 1'b1; enable = 1'b1;
        load(12'h058);
        chk("t1.load", {4'h0, bcd0}, 12'h058);
        fall(); chk("t1.s1", {4'h0, bcd0}, 12'h059);
        chk("t1.nocarry", {11'b0, c0}, 12'h000);
        fall(); chk("t1.s2", {4'h0, bcd0}, 12'h000);
        chk("t1.carry", {11'b0, c0}, 12'h001);
        chk("t1.u2", bcd2, 12'h060);
        fall(); chk("t1.s3", {4'h0, bcd0}, 12'h001);
        chk("t1.carrydone", {11'b0, c0}, 12'h000);

        // load rejection
        load(12'h060);
        chk("t4.err60", {11'b0, e0}, 12'h001);
        chk("t4.hold60", {4'h0, bcd0}, 12'h001);
        chk("t4.u2ok", {11'b0, e2}, 12'h000);
        cyc(1); chk("t4.errpulse", {11'b0, e0}, 12'h000);
        load(12'h01A);
        chk("t4.err1A", {11'b0, e0}, 12'h001);
        chk("t4.hold1A", {4'h0, bcd0}, 12'h001);
        cyc(1);
        load(12'h045);
        chk("t4.ld45", {4'h0, bcd0}, 12'h045);
        chk("t4.noerr", {11'b0, e0}, 12'h000);

        // down wrap versus down stop
        load(12'h001);
        up_down = 1'b0;
        fall(); chk("t2.s1", {4'h0, bcd0}, 12'h000);
        chk("t2.zero", {11'b0, z0}, 12'h001);
        fall(); chk("t2.wrap", {4'h0, bcd0}, 12'h059);
        chk("t2.borrow", {11'b0, c0}, 12'h001);
        chk("t2.nzero", {11'b0, z0}, 12'h000);
        chk("t3.stop", {4'h0, bcd1}, 12'h000);
        chk("t3.nocarry", {11'b0, c1}, 12'h000);
        chk("t6.u2wrap", bcd2, 12'h099);
        cyc(1);
        fall(); chk("t3.stop2", {4'h0, bcd1}, 12'h000);
        chk("t3.zero", {11'b0, z1}, 12'h001);

        // clear beats load beats edge; enable low holds
        tick = 1'b1; cyc(1);
        tick = 1'b0; clear = 1'b1; load_enable = 1'b1; lb = 12'h045; cyc(1);
        clear = 1'b0; load_enable = 1'b0;
        chk("t5.clr", {4'h0, bcd0}, 12'h000);
        chk("t5.nocarry", {11'b0, c0}, 12'h000);
        chk("t5.noerr", {11'b0, e0}, 12'h000);
        enable = 1'b0; up_down = 1'b1;
        fall(); fall();
        chk("t5.hold", {4'h0, bcd0}, 12'h000);
        enable = 1'b1;
        tick = 1'b1; cyc(1);
        tick = 1'b0; load(12'h0AA);
        chk("t5.errdrop", {4'h0, bcd0}, 12'h000);
        chk("t5.err", {11'b0, e0}, 12'h001);

        // 3-digit wrap and asynchronous reset mid-tick-low
        load(12'h099);
        chk("t6.ld", bcd2, 12'h099);
        fall();
        chk("t6.wrap", bcd2, 12'h000);
        chk("t6.carry", {11'b0, c2}, 12'h001);
        load(12'h055);
        tick = 1'b1; cyc(1);
        tick = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("t6.rstbcd0", {4'h0, bcd0}, 12'h000);
        chk("t6.rstbcd2", bcd2, 12'h000);
        chk("t6.rstzero", {11'b0, z2}, 12'h001);
        tick = 1'b1;
        cyc(2);
        reset_n = 1'b1;
        cyc(2);
        chk("t6.norelease", bcd2, 12'h000);
        tick = 1'b0; cyc(1);
        chk("t6.count", bcd2, 12'h001);
        chk("t6.count0", {4'h0, bcd0}, 12'h001);

        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
